// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RISC-V style ID stage -- IF/ID pipeline register, 32-entry
//            register file with write-through reads, main/ALU decoder and
//            immediate extender.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr_f,
    input  logic [WIDTH-1:0] pc_f,
    input  logic [WIDTH-1:0] pc_plus4_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             reg_write_w,
    input  logic [4:0]       rd_w,
    input  logic [WIDTH-1:0] result_w,
    output logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pc_plus4_d,
    output logic [WIDTH-1:0] rd1_d,
    output logic [WIDTH-1:0] rd2_d,
    output logic [WIDTH-1:0] imm_ext_d,
    output logic [4:0]       rs1_d,
    output logic [4:0]       rs2_d,
    output logic [4:0]       rd_d,
    output logic             valid_d,
    output logic             reg_write_d,
    output logic             mem_write_d,
    output logic             branch_d,
    output logic             jump_d,
    output logic             alu_src_d,
    output logic             illegal_d,
    output logic [1:0]       result_src_d,
    output logic [2:0]       alu_control_d
);

    localparam logic [WIDTH-1:0] c_nop     = WIDTH'(32'h0000_0013);
    localparam logic [6:0]       c_op_load = 7'b0000011;
    localparam logic [6:0]       c_op_store= 7'b0100011;
    localparam logic [6:0]       c_op_r    = 7'b0110011;
    localparam logic [6:0]       c_op_i    = 7'b0010011;
    localparam logic [6:0]       c_op_br   = 7'b1100011;
    localparam logic [6:0]       c_op_jal  = 7'b1101111;
    localparam logic [6:0]       c_op_jalr = 7'b1100111;
    localparam logic [6:0]       c_op_lui  = 7'b0110111;

    logic [WIDTH-1:0] r_instr;
    logic             r_valid;
    logic [WIDTH-1:0] r_regs [32];

    logic [31:0] w_instr;
    logic [31:0] w_imm;
    logic        w_reg_write, w_mem_write, w_branch, w_jump, w_alu_src, w_illegal;
    logic [1:0]  w_result_src;
    logic [2:0]  w_alu_control;
    logic [2:0]  w_alu_f3;
    logic        w_f3_ok;

    // IF/ID register: flush beats stall, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr    <= c_nop;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            r_valid    <= 1'b0;
        end else if (flush_d) begin
            r_instr    <= c_nop;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            r_valid    <= 1'b0;
        end else if (!stall_d) begin
            r_instr    <= instr_f;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            r_valid    <= 1'b1;
        end
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (reg_write_w && (rd_w != 5'd0)) begin
            r_regs[rd_w] <= result_w;
        end
    end

    assign w_instr = r_instr[31:0];
    assign rs1_d   = w_instr[19:15];
    assign rs2_d   = w_instr[24:20];
    assign rd_d    = w_instr[11:7];

    // Read ports: x0 reads zero, a same-cycle writeback is forwarded.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rst && (rs1_d != 5'd0)) begin
            rd1_d = (reg_write_w && (rd_w == rs1_d)) ? result_w : r_regs[rs1_d];
        end
        if (rst && (rs2_d != 5'd0)) begin
            rd2_d = (reg_write_w && (rd_w == rs2_d)) ? result_w : r_regs[rs2_d];
        end
    end

    // funct3 to ALU operation shared by R-type and I-ALU instructions.
    always_comb begin
        w_alu_f3 = 3'b000;
        w_f3_ok  = 1'b1;
        case (w_instr[14:12])
            3'b000:  w_alu_f3 = 3'b000;
            3'b111:  w_alu_f3 = 3'b010;
            3'b110:  w_alu_f3 = 3'b011;
            3'b100:  w_alu_f3 = 3'b100;
            3'b010:  w_alu_f3 = 3'b101;
            default: w_f3_ok  = 1'b0;
        endcase
    end

    // Main decoder and immediate selection; unsupported encodings become bubbles.
    always_comb begin
        w_reg_write   = 1'b0;
        w_mem_write   = 1'b0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_alu_src     = 1'b0;
        w_illegal     = 1'b0;
        w_result_src  = 2'b00;
        w_alu_control = 3'b000;
        w_imm         = '0;
        case (w_instr[6:0])
            c_op_load: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b01;
                w_imm        = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            c_op_store: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_imm       = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            c_op_r: begin
                w_reg_write   = w_f3_ok;
                w_illegal     = !w_f3_ok;
                w_alu_control = ((w_instr[14:12] == 3'b000) && w_instr[30]) ? 3'b001 : w_alu_f3;
            end
            c_op_i: begin
                w_reg_write   = w_f3_ok;
                w_illegal     = !w_f3_ok;
                w_alu_src     = 1'b1;
                w_alu_control = w_alu_f3;
                w_imm         = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            c_op_br: begin
                w_branch      = 1'b1;
                w_alu_control = 3'b001;
                w_imm = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
            end
            c_op_jal: begin
                w_jump       = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = 2'b10;
                w_imm = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
            end
            c_op_jalr: begin
                w_jump       = 1'b1;
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b10;
                w_imm        = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            c_op_lui: begin
                w_reg_write   = 1'b1;
                w_alu_src     = 1'b1;
                w_alu_control = 3'b111;
                w_imm         = {w_instr[31:12], 12'b0};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    generate
        if (WIDTH > 32) begin : g_imm_wide
            assign imm_ext_d = {{(WIDTH-32){w_imm[31]}}, w_imm};
        end else begin : g_imm_exact
            assign imm_ext_d = w_imm;
        end
    endgenerate

    // Side-effecting controls are squashed for an invalid slot; everything
    // reads as idle while reset is held.
    assign valid_d       = r_valid;
    assign reg_write_d   = r_valid & w_reg_write;
    assign mem_write_d   = r_valid & w_mem_write;
    assign branch_d      = r_valid & w_branch;
    assign jump_d        = r_valid & w_jump;
    assign illegal_d     = r_valid & w_illegal;
    assign alu_src_d     = rst & w_alu_src;
    assign result_src_d  = rst ? w_result_src  : 2'b00;
    assign alu_control_d = rst ? w_alu_control : 3'b000;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: WIDTH, default 32, datapath/address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 instr_f, pc_f, pc_plus4_f  input  WIDTH each  instruction, PC, PC+4 from fetch.
REQ-005 stall_d  input  1  hold IF/ID contents; flush_d  input  1  squash IF/ID contents (branch/jump taken).
REQ-006 reg_write_w  input  1, rd_w  input  5, result_w  input  WIDTH  writeback port.
REQ-007 pc_d, pc_plus4_d, rd1_d, rd2_d, imm_ext_d  output  WIDTH  registered PCs, register operands, extended immediate.
REQ-008 rs1_d, rs2_d, rd_d  output  5  instr[19:15], instr[24:20], instr[11:7] of the held instruction.
REQ-009 valid_d, reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d, illegal_d  output  1; result_src_d  output  2; alu_control_d  output  3.

Function
REQ-010 IF/ID register SHALL capture instr_f/pc_f/pc_plus4_f on each rising edge and set valid_d=1 when stall_d=0 and flush_d=0.
REQ-011 stall_d=1, flush_d=0: SHALL hold all IF/ID contents.
REQ-012 flush_d=1: SHALL load instr=0x00000013 (NOP), pc=0, pc_plus4=0, valid=0; flush SHALL take priority over stall.
REQ-013 Register file: 32 x WIDTH; x0 SHALL always read 0 and never be written.
REQ-014 Write on rising edge when reg_write_w=1 and rd_w!=0.
REQ-015 Reads combinational; same-cycle write to a read register (rd_w==rs, rd_w!=0, reg_write_w=1) SHALL return result_w (write-through).
REQ-016 Decode (combinational from held instr), result_src 00=ALU,01=mem,10=PC+4:
  - 0000011 lw: reg_write=1, alu_src=1, result_src=01, imm I, alu add.
  - 0100011 sw: mem_write=1, alu_src=1, imm S, alu add.
  - 0110011 R: reg_write=1, alu per funct3/funct7.
  - 0010011 I-ALU: reg_write=1, alu_src=1, imm I, alu per funct3 (funct7 ignored).
  - 1100011 beq/bne: branch=1, imm B, alu sub.
  - 1101111 jal: jump=1, reg_write=1, result_src=10, imm J.
  - 1100111 jalr: jump=1, reg_write=1, alu_src=1, result_src=10, imm I, alu add.
  - 0110111 lui: reg_write=1, alu_src=1, imm U, alu_control=111 (pass B).
REQ-017 alu_control: add 000, sub 001 (R-type funct7[5]=1, funct3 000), and 010, or 011, xor 100, slt 101; other funct3 -> illegal_d=1.
REQ-018 Immediates sign-extended from instr[31]: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; J {31,19:12,20,30:21,0}; U {31:12,12'b0}.
REQ-019 Unknown opcode: illegal_d=1, all enables 0 (bubble); imm_ext_d=0.
REQ-020 valid_d=0 SHALL force reg_write_d, mem_write_d, branch_d, jump_d, illegal_d to 0.

Reset
REQ-021 rst=0 SHALL immediately (no clock) set IF/ID to NOP, pc_d=pc_plus4_d=0, valid_d=0, and clear all 32 registers to 0.
REQ-022 Reset mid-operation SHALL discard held instruction and pending writeback; first capture occurs on first rising edge with rst=1.
REQ-023 All outputs SHALL reflect the reset state combinationally while rst=0 (control outputs 0, rd1_d=rd2_d=0).

Verification
REQ-024 Reset, then instr_f=0x00500093 (addi x1,x0,5), pc_f=0x10 -> next cycle valid_d=1, reg_write_d=1, alu_src_d=1, imm_ext_d=5, rd_d=1, pc_plus4_d=0x14.
REQ-025 reg_write_w=1, rd_w=3, result_w=0xDEADBEEF while held instr reads rs1=3 -> rd1_d=0xDEADBEEF same cycle; write to rd_w=0 -> x0 reads 0.
REQ-026 stall_d=1 for 3 cycles with changing instr_f -> outputs unchanged; stall_d=1 and flush_d=1 -> valid_d=0, NOP held.
REQ-027 Branch 0xFE000EE3 (beq x0,x0,-4) -> branch_d=1, alu_control_d=001, imm_ext_d=0xFFFFFFFC; jal 0x008000EF -> jump_d=1, result_src_d=10, imm_ext_d=8.
REQ-028 Opcode 0x0000007F -> illegal_d=1, all enables 0; async rst pulse mid-cycle -> valid_d=0 and registers read 0 before next edge.
